// File: rtl/datapath_pkg.sv
// Shared constants and ALU operation encoding for the single-bus CPU datapath.
package datapath_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_AND  = 2'd1,
    OP_INC  = 2'd2
  } alu_op_t;

endpackage

// File: rtl/datapath_reg32.sv
// Generic bus register: synchronous clear, load enable, holds otherwise.
module reg32
  import datapath_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, shared bus mux, AND/increment ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic             PCout,
  input  logic             ZHighout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R2out,
  input  logic             R4out,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic             R5in,
  input  logic             R2in,
  input  logic             R4in,
  input  logic             Clock,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             Clear,
  input  logic             R1in,
  input  logic             R3in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             ZHighIn,
  input  logic             ZLowIn,
  input  logic             Cin,
  output logic [WIDTH-1:0] BusMuxOut
);

  logic [WIDTH-1:0]   pc, ir, mar, mdr, y, z_hi, z_lo, hi, lo, c_reg;
  logic [WIDTH-1:0]   r [1:15];
  logic [15:1]        r_in;
  logic [WIDTH-1:0]   mdr_d;
  alu_op_t            alu_op;
  logic [2*WIDTH-1:0] alu_res;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  // Priority bus mux; an X strobe falls through to the next source like a 0.
  always_comb begin
    BusMuxOut = '0;
    if (PCout)         BusMuxOut = pc;
    else if (ZHighout) BusMuxOut = z_hi;
    else if (Zlowout)  BusMuxOut = z_lo;
    else if (MDRout)   BusMuxOut = mdr;
    else if (R2out)    BusMuxOut = r[2];
    else if (R4out)    BusMuxOut = r[4];
  end

  always_comb begin
    alu_op = OP_NONE;
    if (IncPC)    alu_op = OP_INC;
    else if (AND) alu_op = OP_AND;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_INC:  alu_res = {{WIDTH{1'b0}}, BusMuxOut + WIDTH'(1)};
      OP_AND:  alu_res = {{WIDTH{1'b0}}, y & BusMuxOut};
      default: alu_res = '0;
    endcase
  end

  assign mdr_d = Read ? Mdatain : BusMuxOut;

  reg32 u_pc   (.Clock(Clock), .Clear(Clear), .en(PCin),    .d(BusMuxOut),               .q(pc));
  reg32 u_ir   (.Clock(Clock), .Clear(Clear), .en(IRin),    .d(BusMuxOut),               .q(ir));
  reg32 u_mar  (.Clock(Clock), .Clear(Clear), .en(MARin),   .d(BusMuxOut),               .q(mar));
  reg32 u_mdr  (.Clock(Clock), .Clear(Clear), .en(MDRin),   .d(mdr_d),                   .q(mdr));
  reg32 u_y    (.Clock(Clock), .Clear(Clear), .en(Yin),     .d(BusMuxOut),               .q(y));
  reg32 u_z_hi (.Clock(Clock), .Clear(Clear), .en(ZHighIn), .d(alu_res[2*WIDTH-1:WIDTH]), .q(z_hi));
  reg32 u_z_lo (.Clock(Clock), .Clear(Clear), .en(ZLowIn),  .d(alu_res[WIDTH-1:0]),      .q(z_lo));
  reg32 u_hi   (.Clock(Clock), .Clear(Clear), .en(HIin),    .d(BusMuxOut),               .q(hi));
  reg32 u_lo   (.Clock(Clock), .Clear(Clear), .en(LOin),    .d(BusMuxOut),               .q(lo));
  reg32 u_c    (.Clock(Clock), .Clear(Clear), .en(Cin),     .d(BusMuxOut),               .q(c_reg));

  for (genvar i = 1; i <= 15; i++) begin : g_r
    reg32 u_r (.Clock(Clock), .Clear(Clear), .en(r_in[i]), .d(BusMuxOut), .q(r[i]));
  end

  // Registers without a bus output yet stay in the design for hierarchical observation.
  logic unused_regs;
  assign unused_regs = ^{ir, mar, hi, lo, c_reg, r[1], r[3], r[5], r[6], r[7], r[8],
                         r[9], r[10], r[11], r[12], r[13], r[14], r[15]};

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-bus datapath with hand-computed expected values.
module tb_datapath;

  logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read, AND;
  logic        R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
  logic        R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic        Clock, Clear;
  logic [31:0] Mdatain, BusMuxOut;

  int n_cmp = 0;
  int n_bad = 0;

  datapath dut (
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .AND(AND),
    .R5in(R5in), .R2in(R2in), .R4in(R4in), .Clock(Clock), .Mdatain(Mdatain),
    .Clear(Clear), .R1in(R1in), .R3in(R3in), .R6in(R6in), .R7in(R7in),
    .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in), .R12in(R12in),
    .R13in(R13in), .R14in(R14in), .R15in(R15in), .HIin(HIin), .LOin(LOin),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin), .BusMuxOut(BusMuxOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {PCout, ZHighout, Zlowout, MDRout, R2out, R4out} = '0;
    {MARin, PCin, MDRin, IRin, Yin, IncPC, Read, AND} = '0;
    {R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in} = '0;
    {R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
    {HIin, LOin, ZHighIn, ZLowIn, Cin, Clear} = '0;
    Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    #2;
    // Reset
    Clear = 1'b1;
    tick();
    chk("rst_pc",   dut.pc,   64'h0);
    chk("rst_mdr",  dut.mdr,  64'h0);
    chk("rst_z",    {dut.z_hi, dut.z_lo}, 64'h0);
    chk("rst_r2",   dut.r[2], 64'h0);
    chk("rst_bus",  BusMuxOut, 64'h0);

    // Memory -> MDR -> R2/R4/R5
    Mdatain = 32'h22; Read = 1; MDRin = 1; tick();
    chk("mdr_22", dut.mdr, 64'h22);
    MDRout = 1; R2in = 1; #1;
    chk("bus_mdr", BusMuxOut, 64'h22);
    tick();
    chk("r2_22", dut.r[2], 64'h22);
    Mdatain = 32'h24; Read = 1; MDRin = 1; tick();
    MDRout = 1; R4in = 1; tick();
    chk("r4_24", dut.r[4], 64'h24);
    Mdatain = 32'h26; Read = 1; MDRin = 1; tick();
    MDRout = 1; R5in = 1; tick();
    chk("r5_26", dut.r[5], 64'h26);

    // PC increment through Z
    PCout = 1; IncPC = 1; ZLowIn = 1; tick();
    chk("z_inc", {dut.z_hi, dut.z_lo}, 64'h1);
    Zlowout = 1; PCin = 1; tick();
    chk("pc_1", dut.pc, 64'h1);
    PCout = 1; #1;
    chk("bus_pc", BusMuxOut, 64'h1);
    idle();

    // Instruction fetch into IR
    Mdatain = 32'h4A920000; Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
    chk("ir", dut.ir, 64'h4A920000);

    // AND R5 <- R2 & R4
    R2out = 1; Yin = 1; tick();
    chk("y_22", dut.y, 64'h22);
    R4out = 1; AND = 1; ZLowIn = 1; tick();
    chk("z_and", dut.z_lo, 64'h20);
    Zlowout = 1; R5in = 1; tick();
    chk("r5_and", dut.r[5], 64'h20);
    ZHighout = 1; Zlowout = 1; #1;
    chk("bus_zhi_prio", BusMuxOut, 64'h0);
    idle();
    R4out = 1; IncPC = 1; AND = 1; ZLowIn = 1; tick();
    chk("inc_over_and", dut.z_lo, 64'h25);

    // MDR from bus when Read is low
    R4out = 1; MDRin = 1; tick();
    chk("mdr_from_bus", dut.mdr, 64'h24);

    // Wrap-around increment
    Mdatain = 32'hFFFFFFFF; Read = 1; MDRin = 1; tick();
    MDRout = 1; PCin = 1; tick();
    chk("pc_ff", dut.pc, 64'hFFFFFFFF);
    PCout = 1; IncPC = 1; ZLowIn = 1; tick();
    chk("z_wrap", {dut.z_hi, dut.z_lo}, 64'h0);

    // Bus priority, self-reload, fan-out load
    Mdatain = 32'h12345678; Read = 1; MDRin = 1; tick();
    PCout = 1; MDRout = 1; #1;
    chk("bus_pc_prio", BusMuxOut, 64'hFFFFFFFF);
    idle();
    R2out = 1; R2in = 1; tick();
    chk("r2_self", dut.r[2], 64'h22);
    MDRout = 1; HIin = 1; LOin = 1; Cin = 1; MARin = 1; R15in = 1; tick();
    chk("hi_fan", dut.hi, 64'h12345678);
    chk("lo_fan", dut.lo, 64'h12345678);
    chk("c_fan",  dut.c_reg, 64'h12345678);
    chk("mar_fan", dut.mar, 64'h12345678);
    chk("r15_fan", dut.r[15], 64'h12345678);

    // Clear beats a simultaneous load
    Clear = 1; MDRout = 1; R5in = 1; tick();
    chk("clr_r5", dut.r[5], 64'h0);
    chk("clr_hi", dut.hi, 64'h0);
    chk("clr_pc", dut.pc, 64'h0);
    chk("clr_mdr", dut.mdr, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
